sd_ram_loader: RTL

SD_RAM_LOADER -- requirements
Module: sd_ram_loader

---
 rtl/sd_ram_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sd_ram_loader.sv
// Copies num_sectors SD sectors from a sector reader into RAM as little-endian 32-bit words.
// Define SD_LOADER_CHECKSUM_EN to keep a running sum of every word the RAM accepts.
module sd_ram_loader (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] base_sector,
    input  logic [15:0] num_sectors,
    input  logic [31:0] ram_base,
    output logic        rstart,
    output logic [31:0] rsector,
    input  logic        rbusy,
    input  logic        rdone,
    input  logic        outen,
    input  logic [8:0]  outaddr,
    input  logic [7:0]  outbyte,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] sectors_done,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, FLUSH, FIN} state_t;

    state_t      state, state_nx;
    logic [31:0] base_q;
    logic [15:0] num_q;
    logic [31:0] wr_addr;
    logic [8:0]  exp_off;
    logic [23:0] pack;
    logic [31:0] fifo [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count;
    logic        byte_in, push, push_ok, pop, err_set, last_sector, accept;
    logic        unused_rbusy;

    // The reader's busy flag carries nothing rdone does not already tell us.
    assign unused_rbusy = rbusy;

    assign accept      = (state == IDLE) && start;
    assign byte_in     = outen && (state == WAIT);
    assign push        = byte_in && (outaddr[1:0] == 2'd3);
    assign pop         = mem_req && mem_ack;
    assign push_ok     = push && ((count != 3'd4) || pop);
    assign err_set     = (byte_in && (outaddr != exp_off)) || (push && !push_ok);
    assign last_sector = ({1'b0, sectors_done} + 17'd1) >= {1'b0, num_q};

    // The FIFO head is the RAM write port; it only moves on an accepted write.
    assign mem_req   = (count != 3'd0);
    assign mem_addr  = mem_req ? wr_addr : 32'd0;
    assign mem_wdata = mem_req ? fifo[rd_ptr] : 32'd0;

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (num_sectors == 16'd0) ? FIN : REQ;
            end
            REQ:   state_nx = WAIT;
            WAIT:  if (rdone) state_nx = (error || err_set || last_sector) ? FLUSH : REQ;
            FLUSH: if (!mem_req) state_nx = FIN;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rstart       <= 1'b0;
            rsector      <= 32'd0;
            error        <= 1'b0;
            sectors_done <= 16'd0;
            wr_addr      <= 32'd0;
            exp_off      <= 9'd0;
            rd_ptr       <= 2'd0;
            wr_ptr       <= 2'd0;
            count        <= 3'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sectors_done <= 16'd0;
                error        <= 1'b0;
                wr_addr      <= ram_base;
                exp_off      <= 9'd0;
            end
            // rstart is registered so it is low during every REQ cycle between sectors.
            if (state == REQ) begin
                rstart  <= 1'b1;
                rsector <= base_q + {16'd0, sectors_done};
                exp_off <= 9'd0;
            end
            if ((state == WAIT) && rdone) begin
                rstart       <= 1'b0;
                sectors_done <= sectors_done + 16'd1;
            end
            if (byte_in) exp_off <= outaddr + 9'd1;
            if (err_set) error <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                wr_addr <= wr_addr + 32'd4;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= base_sector;
            num_q  <= num_sectors;
        end
        if (byte_in) begin
            case (outaddr[1:0])
                2'd0:    pack[7:0]   <= outbyte;
                2'd1:    pack[15:8]  <= outbyte;
                2'd2:    pack[23:16] <= outbyte;
                default: ;
            endcase
        end
        if (push_ok) fifo[wr_ptr] <= {outbyte, pack};
    end

`ifdef SD_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       checksum <= 32'd0;
        else if (accept) checksum <= 32'd0;
        else if (pop)    checksum <= checksum + mem_wdata;
    end
`else
    assign checksum = 32'd0;
`endif

endmodule
